game_state_ctrl: RTL
====================

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 Parameter DEATH_DELAY_FRAMES, default 60, frames between player death and game-over screen.
REQ-002 Parameter START_DELAY_FRAMES, default 2, frames between accepted start and PLAYING.
REQ-003 clk  input  1  system clock (65 MHz pixel domain).
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 frame_tick  input  1  one-clk pulse per frame (vsync rising edge).
REQ-006 class_sel  input  2  character class chosen in menu; 0 = none.
REQ-007 class_sel_vld  input  1  one-clk pulse, class_sel valid.
REQ-008 game_start  input  1  one-clk start request from screen overlay.
REQ-009 back_to_menu  input  1  one-clk return request from screen overlay.
REQ-010 player_dead  input  1  level, player HP reached zero.
REQ-011 boss_dead  input  1  level, boss HP reached zero.
REQ-012 game_active  output  2  0 = menu, 1 = playing, 2 = game over.
REQ-013 char_class  output  2  latched class.
REQ-014 game_reset  output  1  one-clk pulse, reinitialise player/boss/projectiles.
REQ-015 win_flag  output  1  1 = last game ended by boss death.
REQ-016 freeze  output  1  1 = gameplay motion halted.

Function
REQ-017 States SHALL be MENU, STARTING, PLAYING, DYING, OVER; all outputs registered.
REQ-018 MENU: class_sel_vld SHALL latch class_sel into char_class; game_active=0.
REQ-019 MENU: game_start with char_class!=0 SHALL go to STARTING, load frame counter with START_DELAY_FRAMES; game_start with char_class==0 SHALL be ignored.
REQ-020 STARTING: counter SHALL decrement on frame_tick; at frame_tick with counter==1 go PLAYING and pulse game_reset in the same cycle as the transition; game_active stays 0 until PLAYING.
REQ-021 PLAYING: game_active=1, freeze=0; class_sel_vld SHALL be ignored outside MENU.
REQ-022 PLAYING: boss_dead SHALL go OVER at next frame_tick with win_flag=1; boss_dead has priority over simultaneous player_dead.
REQ-023 PLAYING: player_dead (without boss_dead) SHALL go DYING immediately, load counter with DEATH_DELAY_FRAMES, win_flag=0.
REQ-024 DYING: game_active=1, freeze=1; counter decrements per frame_tick; at counter==1 and frame_tick go OVER; boss_dead in DYING SHALL be ignored.
REQ-025 OVER: game_active=2, freeze=1; back_to_menu SHALL go MENU, clear char_class to 0; win_flag held until next game_reset.
REQ-026 game_start outside MENU and back_to_menu outside OVER SHALL be ignored.
REQ-027 Counter width SHALL be ceil(log2(max delay+1)) bits; delay parameter 0 SHALL be treated as 1.
REQ-028 frame_tick coinciding with any request SHALL be processed in the same cycle; no request is buffered across states.

Reset
REQ-029 On rst: state MENU, game_active=0, char_class=0, game_reset=0, win_flag=0, freeze=0, counter=0.
REQ-030 rst asserted mid-game SHALL return to MENU without a game_reset pulse.

Structure
REQ-031 State enum and game_active encodings (GA_MENU=0, GA_PLAY=1, GA_OVER=2) SHALL live in vga_pkg (or shared game_pkg), used also by the screen overlay.
REQ-032 Single module, no sub-modules; frame counter inline.

Verification
REQ-033 class_sel=2 vld, game_start, 2 frame_ticks -> game_active 0->1, one game_reset pulse, char_class=2.
REQ-034 game_start with char_class=0 -> state stays MENU, no game_reset.
REQ-035 PLAYING, player_dead -> freeze=1 immediately, game_active=2 exactly on 60th frame_tick, win_flag=0.
REQ-036 PLAYING, boss_dead and player_dead same cycle -> OVER at next frame_tick, win_flag=1.
REQ-037 OVER, back_to_menu -> game_active=0, char_class=0; subsequent back_to_menu ignored.
REQ-038 rst during DYING counter=30 -> all outputs at reset values, next frame_tick no change.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions for the game state controller and the screen overlay.
//   game_state_e : controller FSM states
//   GA_*         : encodings of the game_active output
//   eff_delay()  : maps a frame-delay parameter onto the value actually loaded
package game_pkg;

  typedef enum logic [2:0] {
    StMenu,
    StStarting,
    StPlaying,
    StDying,
    StOver
  } game_state_e;

  localparam logic [1:0] GA_MENU = 2'd0;
  localparam logic [1:0] GA_PLAY = 2'd1;
  localparam logic [1:0] GA_OVER = 2'd2;

  // A zero delay would never hit the count==1 exit, so it behaves as one frame.
  function automatic int unsigned eff_delay(input int unsigned frames);
    return (frames == 0) ? 1 : frames;
  endfunction

endpackage

// File: rtl/game_state_ctrl.sv
// Top-level game flow controller: menu -> starting -> playing -> dying/over -> menu.
// All outputs are registered; the frame delay counter lives inline.
//   clk           : system clock (pixel domain)
//   rst           : asynchronous active-high reset
//   frame_tick    : one-clk pulse per frame
//   class_sel     : class chosen in the menu (0 = none), qualified by class_sel_vld
//   game_start    : one-clk start request (honoured only in the menu with a class chosen)
//   back_to_menu  : one-clk return request (honoured only on the game-over screen)
//   player_dead   : level, player HP is zero
//   boss_dead     : level, boss HP is zero
//   game_active   : GA_MENU / GA_PLAY / GA_OVER
//   char_class    : latched class
//   game_reset    : one-clk pulse to reinitialise the play field
//   win_flag      : last game ended by boss death
//   freeze        : gameplay motion halted
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned DEATH_DELAY_FRAMES = 60,
  parameter int unsigned START_DELAY_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [1:0] class_sel,
  input  logic       class_sel_vld,
  input  logic       game_start,
  input  logic       back_to_menu,
  input  logic       player_dead,
  input  logic       boss_dead,
  output logic [1:0] game_active,
  output logic [1:0] char_class,
  output logic       game_reset,
  output logic       win_flag,
  output logic       freeze
);

  localparam int unsigned DeathEff = eff_delay(DEATH_DELAY_FRAMES);
  localparam int unsigned StartEff = eff_delay(START_DELAY_FRAMES);
  localparam int unsigned MaxDelay = (DeathEff > StartEff) ? DeathEff : StartEff;
  localparam int unsigned CntW     = $clog2(MaxDelay + 1);

  localparam logic [CntW-1:0] DeathLoad = CntW'(DeathEff);
  localparam logic [CntW-1:0] StartLoad = CntW'(StartEff);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  game_state_e     state_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StMenu;
      cnt_q       <= '0;
      game_active <= GA_MENU;
      char_class  <= 2'd0;
      game_reset  <= 1'b0;
      win_flag    <= 1'b0;
      freeze      <= 1'b0;
    end else begin
      game_reset <= 1'b0;
      unique case (state_q)
        StMenu: begin
          if (class_sel_vld) begin
            char_class <= class_sel;
          end
          // Uses the class already latched, not one arriving in the same cycle.
          if (game_start && (char_class != 2'd0)) begin
            state_q <= StStarting;
            cnt_q   <= StartLoad;
          end
        end

        StStarting: begin
          if (frame_tick) begin
            if (cnt_q <= CntOne) begin
              state_q     <= StPlaying;
              game_active <= GA_PLAY;
              game_reset  <= 1'b1;
              win_flag    <= 1'b0;
              freeze      <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CntOne;
            end
          end
        end

        StPlaying: begin
          // Boss death wins over a simultaneous player death and waits for a frame edge.
          if (boss_dead) begin
            if (frame_tick) begin
              state_q     <= StOver;
              game_active <= GA_OVER;
              win_flag    <= 1'b1;
              freeze      <= 1'b1;
            end
          end else if (player_dead) begin
            state_q  <= StDying;
            cnt_q    <= DeathLoad;
            win_flag <= 1'b0;
            freeze   <= 1'b1;
          end
        end

        StDying: begin
          if (frame_tick) begin
            if (cnt_q <= CntOne) begin
              state_q     <= StOver;
              game_active <= GA_OVER;
            end else begin
              cnt_q <= cnt_q - CntOne;
            end
          end
        end

        StOver: begin
          // win_flag intentionally kept until the next game_reset.
          if (back_to_menu) begin
            state_q     <= StMenu;
            game_active <= GA_MENU;
            char_class  <= 2'd0;
            freeze      <= 1'b0;
          end
        end

        default: begin
          state_q     <= StMenu;
          game_active <= GA_MENU;
          freeze      <= 1'b0;
        end
      endcase
    end
  end

endmodule
